// File: rtl/instr_fetch_if.sv
// Handshake and memory bus between the fetch sequencer, its controller and the
// synchronous instruction memory.
interface instr_fetch_if #(
   parameter int unsigned AW = 8
);
   logic          fetch_req;
   logic          jump_en;
   logic [AW-1:0] jump_addr;
   logic [7:0]    im_data;
   logic [AW-1:0] im_addr;
   logic          im_rd;
   logic [7:0]    instr;
   logic          instr_valid;
   logic          busy;
   logic [AW-1:0] pc;

   modport master (
      output fetch_req, jump_en, jump_addr, im_data,
      input  im_addr, im_rd, instr, instr_valid, busy, pc
   );

   modport slave (
      input  fetch_req, jump_en, jump_addr, im_data,
      output im_addr, im_rd, instr, instr_valid, busy, pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, runs fixed-latency reads from the
// instruction memory and hands each instruction over with a one-cycle strobe.
module instr_fetch #(
   parameter int unsigned AW       = 8,
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned RESET_PC = 0
) (
   input logic          clk,
   input logic          RST,
   instr_fetch_if.slave bus
);

   localparam logic [AW-1:0] PcInit   = AW'(RESET_PC);
   localparam logic [2:0]    WaitInit = 3'(MEM_LAT - 1);

   typedef enum logic [1:0] {StIdle, StRead, StWait, StDone} state_e;

   state_e        state_q;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] im_addr_q;
   logic          im_rd_q;
   logic [7:0]    instr_q;
   logic          instr_valid_q;
   logic          busy_q;
   logic [2:0]    cnt_q;
   logic          pend_q;
   logic [AW-1:0] pend_addr_q;
   logic [AW-1:0] pc_next;

   // A jump arriving on the capture cycle is the newest one, so it wins.
   always_comb begin
      pc_next = pc_q + AW'(1);
      if (bus.jump_en) begin
         pc_next = bus.jump_addr;
      end else if (pend_q) begin
         pc_next = pend_addr_q;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q       <= StIdle;
         pc_q          <= PcInit;
         im_addr_q     <= PcInit;
         im_rd_q       <= 1'b0;
         instr_q       <= 8'h00;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         cnt_q         <= 3'd0;
         pend_q        <= 1'b0;
         pend_addr_q   <= '0;
      end else begin
         im_rd_q       <= 1'b0;
         instr_valid_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.jump_en) begin
                  pc_q      <= bus.jump_addr;
                  im_addr_q <= bus.jump_addr;
               end
               if (bus.fetch_req) begin
                  state_q <= StRead;
                  im_rd_q <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            StRead: begin
               cnt_q   <= WaitInit;
               state_q <= StWait;
               if (bus.jump_en) begin
                  pend_q      <= 1'b1;
                  pend_addr_q <= bus.jump_addr;
               end
            end
            StWait: begin
               if (cnt_q == 3'd0) begin
                  instr_q       <= bus.im_data;
                  instr_valid_q <= 1'b1;
                  busy_q        <= 1'b0;
                  pc_q          <= pc_next;
                  im_addr_q     <= pc_next;
                  pend_q        <= 1'b0;
                  state_q       <= StDone;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
                  if (bus.jump_en) begin
                     pend_q      <= 1'b1;
                     pend_addr_q <= bus.jump_addr;
                  end
               end
            end
         endcase
      end
   end

   assign bus.im_addr     = im_addr_q;
   assign bus.im_rd       = im_rd_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.busy        = busy_q;
   assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (read latency 1 and 3) share one
// stimulus stream and are checked every cycle against a timeline model.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       RST = 1'b0;
   logic       fetch_req = 1'b0;
   logic       jump_en = 1'b0;
   logic [7:0] jump_addr = 8'h00;
   logic [7:0] im_data1 = 8'h00;
   logic [7:0] im_data3 = 8'h00;

   int tests = 0;
   int fails = 0;

   logic [7:0] mem [256];
   logic [8:0] h1 [8];
   logic [8:0] h3 [8];

   instr_fetch_if #(.AW(8)) bus1 ();
   instr_fetch_if #(.AW(8)) bus3 ();

   instr_fetch #(.AW(8), .MEM_LAT(1), .RESET_PC(0)) dut1 (.clk(clk), .RST(RST), .bus(bus1));
   instr_fetch #(.AW(8), .MEM_LAT(3), .RESET_PC(0)) dut3 (.clk(clk), .RST(RST), .bus(bus3));

   assign bus1.fetch_req = fetch_req;
   assign bus1.jump_en   = jump_en;
   assign bus1.jump_addr = jump_addr;
   assign bus1.im_data   = im_data1;
   assign bus3.fetch_req = fetch_req;
   assign bus3.jump_en   = jump_en;
   assign bus3.jump_addr = jump_addr;
   assign bus3.im_data   = im_data3;

   logic [1:0][7:0] o_pc, o_ima, o_ins;
   logic [1:0]      o_rd, o_iv, o_bz;
   assign o_pc  = {bus3.pc, bus1.pc};
   assign o_ima = {bus3.im_addr, bus1.im_addr};
   assign o_ins = {bus3.instr, bus1.instr};
   assign o_rd  = {bus3.im_rd, bus1.im_rd};
   assign o_iv  = {bus3.instr_valid, bus1.instr_valid};
   assign o_bz  = {bus3.busy, bus1.busy};

   always #5 clk = ~clk;

   // Memory: data for a read shows up exactly MEM_LAT cycles after its im_rd
   // cycle; any other cycle carries random garbage.
   initial begin
      for (int i = 0; i < 8; i++) begin
         h1[i] = '0;
         h3[i] = '0;
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 7; i > 0; i--) begin
         h1[i] = h1[i-1];
         h3[i] = h3[i-1];
      end
      h1[0] = {bus1.im_rd, bus1.im_addr};
      h3[0] = {bus3.im_rd, bus3.im_addr};
      im_data1 = h1[1][8] ? mem[h1[1][7:0]] : 8'($urandom);
      im_data3 = h3[3][8] ? mem[h3[3][7:0]] : 8'($urandom);
   end

   // Model: n counts edges since the fetch was accepted (0 = nothing running).
   // Read cycle is n=1, memory wait n=2..L+1, hand-over cycle n=L+2.
   int         lat [2] = '{1, 3};
   int         n [2];
   logic [7:0] m_pc [2], m_instr [2], m_fa [2], m_pa [2];
   bit         m_pend [2];

   always @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < 2; k++) begin
            n[k] <= 0;
            m_pc[k] <= 8'h00;
            m_instr[k] <= 8'h00;
            m_fa[k] <= 8'h00;
            m_pa[k] <= 8'h00;
            m_pend[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (n[k] == lat[k] + 1) begin
               m_instr[k] <= mem[m_fa[k]];
               m_pc[k]    <= jump_en ? jump_addr : (m_pend[k] ? m_pa[k] : m_pc[k] + 8'd1);
               m_pend[k]  <= 1'b0;
               n[k]       <= lat[k] + 2;
            end else if (n[k] >= 1 && n[k] <= lat[k]) begin
               if (jump_en) begin
                  m_pend[k] <= 1'b1;
                  m_pa[k]   <= jump_addr;
               end
               n[k] <= n[k] + 1;
            end else begin
               if (fetch_req) begin
                  n[k]    <= 1;
                  m_fa[k] <= jump_en ? jump_addr : m_pc[k];
               end else begin
                  n[k] <= 0;
               end
               if (jump_en) m_pc[k] <= jump_addr;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!RST) begin
         for (int k = 0; k < 2; k++) begin
            logic e_rd, e_bz, e_iv;
            e_rd = (n[k] == 1);
            e_bz = (n[k] >= 1) && (n[k] <= lat[k] + 1);
            e_iv = (n[k] == lat[k] + 2);
            tests++;
            if (o_pc[k] !== m_pc[k] || o_ima[k] !== m_pc[k] || o_rd[k] !== e_rd ||
                o_bz[k] !== e_bz || o_iv[k] !== e_iv || o_ins[k] !== m_instr[k]) begin
               fails++;
               $display("FAIL model lat%0d t=%0t: got pc=%h ima=%h rd=%b busy=%b iv=%b instr=%h required pc=%h ima=%h rd=%b busy=%b iv=%b instr=%h",
                        lat[k], $time, o_pc[k], o_ima[k], o_rd[k], o_bz[k], o_iv[k], o_ins[k],
                        m_pc[k], m_pc[k], e_rd, e_bz, e_iv, m_instr[k]);
            end
         end
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      RST = 1'b1;
      fetch_req = 1'b0;
      jump_en = 1'b0;
      jump_addr = 8'h00;
      @(posedge clk);
      #3 RST = 1'b0;
      step();
   endtask

   int vcyc[$];
   int raddr[$];
   int rd_cnt;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h00] = 8'hA3;
      mem[8'h01] = 8'h5C;
      #1 RST = 1'b1;
      #2;
      lit("reset pc", bus1.pc, 0);
      lit("reset im_addr", bus1.im_addr, 0);
      lit("reset outputs", {bus1.instr, bus1.instr_valid, bus1.busy, bus1.im_rd}, 0);
      do_reset();

      // Single fetches on the latency-1 instance.
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      lit("c1 im_rd", bus1.im_rd, 1);
      lit("c1 im_addr", bus1.im_addr, 8'h00);
      step();
      step();
      lit("c3 instr", bus1.instr, 8'hA3);
      lit("c3 valid", bus1.instr_valid, 1);
      lit("c3 pc", bus1.pc, 8'h01);
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      step();
      step();
      lit("2nd instr", bus1.instr, 8'h5C);
      lit("2nd pc", bus1.pc, 8'h02);

      // Reset in the middle of a read.
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      step();
      #2 RST = 1'b1;
      #1;
      lit("async rst pc", bus1.pc, 0);
      lit("async rst instr", bus1.instr, 0);
      lit("async rst valid", bus1.instr_valid, 0);
      lit("async rst busy", bus1.busy, 0);
      #2 RST = 1'b0;
      step();
      for (int c = 0; c < 4; c++) begin
         lit("no valid after rst", bus1.instr_valid, 0);
         step();
      end

      // Continuous fetch_req on the latency-3 instance.
      do_reset();
      fetch_req = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (bus3.instr_valid) vcyc.push_back(c);
         if (bus3.im_rd) raddr.push_back(int'(bus3.im_addr));
      end
      fetch_req = 1'b0;
      lit("lat3 valid count", vcyc.size(), 3);
      if (vcyc.size() >= 3) begin
         lit("lat3 first valid", vcyc[0], 5);
         lit("lat3 gap1", vcyc[1] - vcyc[0], 5);
         lit("lat3 gap2", vcyc[2] - vcyc[1], 5);
      end
      lit("lat3 read count", raddr.size(), 4);
      if (raddr.size() >= 3) begin
         lit("lat3 addr0", raddr[0], 8'h00);
         lit("lat3 addr1", raddr[1], 8'h01);
         lit("lat3 addr2", raddr[2], 8'h02);
      end
      repeat (6) step();

      // Jump and fetch in the same idle cycle.
      do_reset();
      jump_en = 1'b1;
      jump_addr = 8'h05;
      step();
      jump_en = 1'b0;
      lit("idle jump pc", bus1.pc, 8'h05);
      jump_en = 1'b1;
      jump_addr = 8'h40;
      fetch_req = 1'b1;
      step();
      jump_en = 1'b0;
      fetch_req = 1'b0;
      lit("jump read rd", bus1.im_rd, 1);
      lit("jump read addr", bus1.im_addr, 8'h40);
      step();
      step();
      lit("jump instr", bus1.instr, mem[8'h40]);
      lit("jump pc", bus1.pc, 8'h41);
      repeat (4) step();

      // Two jumps while the latency-3 read is in flight; last one wins.
      do_reset();
      jump_en = 1'b1;
      jump_addr = 8'h10;
      step();
      jump_en = 1'b0;
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      step();
      jump_en = 1'b1;
      jump_addr = 8'h80;
      step();
      jump_addr = 8'h90;
      step();
      jump_en = 1'b0;
      step();
      lit("busy jump instr", bus3.instr, mem[8'h10]);
      lit("busy jump valid", bus3.instr_valid, 1);
      lit("busy jump pc", bus3.pc, 8'h90);
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      lit("after jump rd", bus3.im_rd, 1);
      lit("after jump addr", bus3.im_addr, 8'h90);
      repeat (6) step();

      // PC wrap at FF, and a fetch_req pulse during the wait is dropped.
      do_reset();
      jump_en = 1'b1;
      jump_addr = 8'hFF;
      fetch_req = 1'b1;
      step();
      jump_en = 1'b0;
      fetch_req = 1'b0;
      rd_cnt = int'(bus1.im_rd);
      step();
      rd_cnt += int'(bus1.im_rd);
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      rd_cnt += int'(bus1.im_rd);
      lit("wrap instr", bus1.instr, mem[8'hFF]);
      lit("wrap pc", bus1.pc, 8'h00);
      for (int c = 0; c < 5; c++) begin
         step();
         rd_cnt += int'(bus1.im_rd);
      end
      lit("wrap read count", rd_cnt, 1);
      lit("wrap idle busy", bus1.busy, 0);

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         fetch_req = ($urandom_range(0, 1) == 1);
         jump_en = ($urandom_range(0, 6) == 0);
         jump_addr = 8'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            #2 RST = 1'b1;
            #1;
            lit("rand rst lat1", {bus1.pc, bus1.instr, bus1.instr_valid, bus1.busy}, 0);
            lit("rand rst lat3", {bus3.pc, bus3.instr, bus3.instr_valid, bus3.busy}, 0);
            #3 RST = 1'b0;
         end
         step();
      end
      fetch_req = 1'b0;
      jump_en = 1'b0;
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch sequencer that sits between the instruction memory and the instruction register.
- Holds the program counter (PC) and issues read cycles to the synchronous instruction memory, waiting a fixed read latency.
- Presents the returned 8-bit instruction plus a one-cycle valid strobe. The controller loads that instruction into the instruction register.
- Handles controller-requested jumps: absolute PC load, queued if a read is already in flight.

Parameters:
- AW, 8, PC / instruction-memory address width in bits.
- MEM_LAT, 1, instruction-memory read latency in cycles, counted after the im_rd cycle. Legal range 1..7.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- fetch_req  in  1  controller request to fetch the instruction at PC.
- jump_en  in  1  single-cycle strobe to load PC with jump_addr.
- jump_addr  in  AW  jump target address.
- im_data  in  8  instruction memory read data.
- im_addr  out  AW  instruction memory address.
- im_rd  out  1  instruction memory read enable.
- instr  out  8  last fetched instruction; feeds the instruction register input.
- instr_valid  out  1  one-cycle strobe: instr is new this cycle.
- busy  out  1  fetch in progress; fetch_req is ignored while high.
- pc  out  AW  current program counter.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, pc=RESET_PC, instr=8'h00.
  - instr_valid=0, im_rd=0, busy=0, im_addr=RESET_PC.
  - Wait counter and pending-jump flag cleared.
  - Reset mid-fetch abandons the read; no instr_valid is produced.
- States are IDLE, READ, WAIT and DONE.
- IDLE:
  - busy=0.
  - jump_en=1 loads pc<=jump_addr.
  - If fetch_req=1 in the same cycle, go to READ using the new (jumped) PC. Jump has priority.
  - fetch_req=1 alone: go to READ.
- READ (one cycle):
  - im_rd=1, im_addr=pc, busy=1.
  - Load wait counter with MEM_LAT-1; go to WAIT.
- WAIT (MEM_LAT cycles):
  - im_rd=0, busy=1; counter decrements each cycle.
  - On the counter=0 cycle: capture instr<=im_data on the closing edge, then go to DONE.
  - The PC update on that same edge depends on the pending-jump flag:
    - Flag set: pc<=pending address and clear the flag.
    - Flag clear: pc<=pc+1, wrapping modulo 2^AW (all-ones -> 0).
- DONE (one cycle):
  - instr_valid=1, busy=0.
  - DONE accepts fetch_req and jump_en exactly as IDLE does (back-to-back fetch allowed); otherwise go to IDLE.
- Latency and throughput:
  - From fetch_req sampled in IDLE to the instr_valid cycle: MEM_LAT+2 cycles.
  - Back-to-back throughput: one instruction per MEM_LAT+2 cycles.
- im_addr:
  - Registered; equals pc in all states.
  - Held stable through READ and WAIT; pc does not change until the capture edge.
- Jump while busy (jump_en in READ or WAIT):
  - Store jump_addr and set the pending flag.
  - The in-flight fetch completes normally and still delivers its instruction.
  - The pending address replaces the pc+1 increment.
  - A second jump_en before completion overwrites the pending address (last wins).
- fetch_req in READ or WAIT is ignored, not queued. The controller must re-assert it in DONE or IDLE.
- instr holds its value between fetches. instr_valid is never high for more than one consecutive cycle unless back-to-back fetches occur.
- im_data is don't-care outside the capture cycle.

Test Plan:
- Reset with MEM_LAT=1: assert RST mid-WAIT → pc=0, instr=00, instr_valid=0, busy=0 immediately (asynchronously); no valid strobe after release.
- Memory holds 0x00:A3, 0x01:5C; fetch_req pulse at cycle 0 → im_rd=1 with im_addr=00 in cycle 1; instr=A3 and instr_valid=1 in cycle 3; pc=01 → second fetch gives instr=5C, pc=02.
- MEM_LAT=3; fetch_req held high continuously → instr_valid every 5 cycles; consecutive addresses 00, 01, 02 read in order.
- IDLE, pc=05, jump_en=1 with jump_addr=40 and fetch_req=1 in the same cycle → im_addr=40 during READ; instr=mem[40]; pc=41 afterwards.
- During WAIT of a fetch at pc=10: jump_en with jump_addr=80, then jump_en with jump_addr=90 → instr=mem[10] delivered; pc=90 (not 11 or 80); next fetch reads 90.
- AW=8, pc=FF, fetch → instr=mem[FF], pc wraps to 00; a fetch_req pulse during WAIT produces no extra fetch.
